// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: non-overlapping 2x2 max pooling over a raster-ordered
// signed feature-map stream, using a half-row buffer of horizontal maxima.
// Optional build macro MAXPOOL_RELU_EN clamps negative inputs to zero before pooling.
module maxpool_2x2_stream #(
  parameter int unsigned double_word_length = 16,
  parameter int unsigned map_size           = 24,
  parameter int unsigned cnt_width          = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic signed [double_word_length-1:0] data_in,
  output logic                                 out_valid,
  output logic signed [double_word_length-1:0] data_out,
  output logic                                 done
);

  localparam int unsigned HALF  = map_size / 2;
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [cnt_width-1:0] LAST = cnt_width'(map_size - 1);

  logic [cnt_width-1:0]                 col;
  logic [cnt_width-1:0]                 row;
  logic [IDX_W-1:0]                     idx;
  logic signed [double_word_length-1:0] pair;
  logic signed [double_word_length-1:0] sample;
  logic signed [double_word_length-1:0] h;
  logic signed [double_word_length-1:0] pooled;
  logic signed [double_word_length-1:0] half_buf [HALF];

  // Buffer slot is the horizontal pair index, i.e. col >> 1.
  assign idx = col[IDX_W:1];

  // Input conditioning and the two signed max comparators.
  always_comb begin
`ifdef MAXPOOL_RELU_EN
    sample = data_in[double_word_length-1] ? '0 : data_in;
`else
    sample = data_in;
`endif
    h      = (sample > pair) ? sample : pair;
    pooled = (half_buf[idx] > h) ? half_buf[idx] : h;
  end

  // Counters, pair register and registered pooled output.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      pair      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (in_valid) begin
        if (!col[0]) begin
          pair <= sample;
        end else if (row[0]) begin
          out_valid <= 1'b1;
          data_out  <= pooled;
          done      <= (row == LAST) && (col == LAST);
        end
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Even rows store their horizontal maxima for the row below.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && col[0] && !row[0]) begin
      half_buf[idx] <= h;
    end
  end

endmodule
